// File: rtl/key_action_ctrl_if.sv
// key_action_ctrl_if: keycode/map inputs and per-action outputs of the key action controller.
interface key_action_ctrl_if #(
    parameter int NUM_SLOTS   = 4,
    parameter int NUM_ACTIONS = 3
);
    logic                     tick;
    logic [NUM_SLOTS*8-1:0]   keycodes;
    logic [NUM_ACTIONS*8-1:0] key_map;
    logic [NUM_ACTIONS-1:0]   held;
    logic [NUM_ACTIONS-1:0]   press_pulse;
    logic [NUM_ACTIONS-1:0]   release_pulse;
    logic [NUM_ACTIONS-1:0]   fire;

    modport master (
        output tick, keycodes, key_map,
        input  held, press_pulse, release_pulse, fire
    );

    modport slave (
        input  tick, keycodes, key_map,
        output held, press_pulse, release_pulse, fire
    );
endinterface

// File: rtl/key_action_ctrl.sv
// key_action_ctrl: maps programmable HID keycodes to per-action held/press/release/auto-repeat fire.
// Optional macro KEYCTL_LR_PRIORITY_EN: actions 0/1 become a last-pressed-wins left/right pair.
module key_action_ctrl #(
    parameter int NUM_SLOTS     = 4,
    parameter int NUM_ACTIONS   = 3,
    parameter int REPEAT_DELAY  = 20,
    parameter int REPEAT_PERIOD = 6
) (
    input  logic             Clk,
    input  logic             Reset_n,
    key_action_ctrl_if.slave bus
);
    localparam int MAX_CNT = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int CW      = $clog2(MAX_CNT + 1);
    localparam logic [CW-1:0] DELAY_LAST  = CW'((REPEAT_DELAY > 0) ? REPEAT_DELAY - 1 : 0);
    localparam logic [CW-1:0] PERIOD_LAST = CW'((REPEAT_PERIOD > 0) ? REPEAT_PERIOD - 1 : 0);

    typedef enum logic [1:0] {IDLE, FIRST, REPEAT} state_t;

    state_t                 st  [NUM_ACTIONS];
    logic [CW-1:0]          cnt [NUM_ACTIONS];
    logic                   rollover;
    logic [NUM_ACTIONS-1:0] match;
    logic [NUM_ACTIONS-1:0] rise;
    logic [NUM_ACTIONS-1:0] fall;
    logic [NUM_ACTIONS-1:0] held_r;
    logic [NUM_ACTIONS-1:0] press_r;
    logic [NUM_ACTIONS-1:0] release_r;
    logic [NUM_ACTIONS-1:0] fire_r;
    logic [NUM_ACTIONS-1:0] lose;

    // ErrorRollOver in any slot means the report contents cannot be trusted this cycle.
    always_comb begin
        rollover = 1'b0;
        for (int s = 0; s < NUM_SLOTS; s++)
            if (bus.keycodes[8*s +: 8] == 8'h01) rollover = 1'b1;
    end

    // An action matches when its mapped (non-zero) keycode appears in any slot.
    always_comb begin
        match = '0;
        for (int a = 0; a < NUM_ACTIONS; a++)
            for (int s = 0; s < NUM_SLOTS; s++)
                if (bus.key_map[8*a +: 8] != 8'h00 && bus.keycodes[8*s +: 8] == bus.key_map[8*a +: 8])
                    match[a] = 1'b1;
    end

    // Press and release events, both frozen while the report is in rollover.
    always_comb begin
        rise = '0;
        fall = '0;
        for (int a = 0; a < NUM_ACTIONS; a++) begin
            rise[a] = !rollover && match[a] && st[a] == IDLE;
            fall[a] = !rollover && !match[a] && st[a] != IDLE;
        end
    end

    // Per-action hold/auto-repeat FSM; release wins over a coincident tick fire.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            for (int a = 0; a < NUM_ACTIONS; a++) begin
                st[a]  <= IDLE;
                cnt[a] <= '0;
            end
            held_r    <= '0;
            press_r   <= '0;
            release_r <= '0;
            fire_r    <= '0;
        end else begin
            for (int a = 0; a < NUM_ACTIONS; a++) begin
                press_r[a]   <= rise[a];
                release_r[a] <= fall[a];
                fire_r[a]    <= rise[a];
                if (rise[a]) begin
                    held_r[a] <= 1'b1;
                    cnt[a]    <= '0;
                    st[a]     <= FIRST;
                end else if (fall[a]) begin
                    held_r[a] <= 1'b0;
                    cnt[a]    <= '0;
                    st[a]     <= IDLE;
                end else if (bus.tick && st[a] == FIRST && REPEAT_DELAY != 0) begin
                    if (cnt[a] == DELAY_LAST) begin
                        fire_r[a] <= 1'b1;
                        cnt[a]    <= '0;
                        st[a]     <= REPEAT;
                    end else begin
                        cnt[a] <= cnt[a] + 1'b1;
                    end
                end else if (bus.tick && st[a] == REPEAT) begin
                    if (cnt[a] == PERIOD_LAST) begin
                        fire_r[a] <= 1'b1;
                        cnt[a]    <= '0;
                    end else begin
                        cnt[a] <= cnt[a] + 1'b1;
                    end
                end
            end
        end
    end

`ifdef KEYCTL_LR_PRIORITY_EN
    logic win;

    // Remember which of the left/right pair went down last; a simultaneous press goes to action 1.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n)
            win <= 1'b0;
        else if (rise[1])
            win <= 1'b1;
        else if (rise[0])
            win <= 1'b0;
    end

    // While both are down, hide the held level and fires of the side that did not win.
    always_comb begin
        lose    = '0;
        lose[0] = held_r[0] & held_r[1] & win;
        lose[1] = held_r[0] & held_r[1] & ~win;
    end
`else
    assign lose = '0;
`endif

    assign bus.held          = held_r & ~lose;
    assign bus.fire          = fire_r & ~lose;
    assign bus.press_pulse   = press_r;
    assign bus.release_pulse = release_r;
endmodule

// File: tb/tb_key_action_ctrl.sv
// tb_key_action_ctrl: directed vector table plus multi-cycle sequences for key_action_ctrl.
module tb_key_action_ctrl;
    logic clk;
    logic rst_n;
    int   errors;
    int   checks;

    key_action_ctrl_if #(.NUM_SLOTS(4), .NUM_ACTIONS(3)) bus ();

    key_action_ctrl #(
        .NUM_SLOTS(4), .NUM_ACTIONS(3), .REPEAT_DELAY(20), .REPEAT_PERIOD(6)
    ) dut (
        .Clk(clk),
        .Reset_n(rst_n),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [23:0] km;
        logic [31:0] kc;
        logic [2:0]  h;
        logic [2:0]  p;
        logic [2:0]  r;
        logic [2:0]  f;
    } vec_t;

    vec_t v [17];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic cyc(input logic t);
        @(negedge clk);
        bus.tick = t;
        @(posedge clk);
        #1;
    endtask

    int nf, np, nr, drop, stray, first_t, second_t, last_t;

    initial begin
        errors = 0;
        checks = 0;
        bus.tick = 1'b0;
        bus.keycodes = '0;
        bus.key_map = 24'h1A0704;
        rst_n = 1'b0;

        v[0]  = '{24'h1A0704, 32'h00000000, 3'b000, 3'b000, 3'b000, 3'b000};
        v[1]  = '{24'h1A0704, 32'h00000004, 3'b001, 3'b001, 3'b000, 3'b001};
        v[2]  = '{24'h1A0704, 32'h00000004, 3'b001, 3'b000, 3'b000, 3'b000};
        v[3]  = '{24'h1A0704, 32'h00000000, 3'b000, 3'b000, 3'b001, 3'b000};
        v[4]  = '{24'h1A0704, 32'h00001A04, 3'b101, 3'b101, 3'b000, 3'b101};
        v[5]  = '{24'h1A0704, 32'h01010101, 3'b101, 3'b000, 3'b000, 3'b000};
        v[6]  = '{24'h1A0704, 32'h00000000, 3'b000, 3'b000, 3'b101, 3'b000};
        v[7]  = '{24'h1A0704, 32'h01000007, 3'b000, 3'b000, 3'b000, 3'b000};
        v[8]  = '{24'h1A0704, 32'h00000007, 3'b010, 3'b010, 3'b000, 3'b010};
        v[9]  = '{24'h1A0704, 32'h1A000007, 3'b110, 3'b100, 3'b000, 3'b100};
        v[10] = '{24'h1A0504, 32'h1A000007, 3'b100, 3'b000, 3'b010, 3'b000};
        v[11] = '{24'h1A0500, 32'h00000000, 3'b000, 3'b000, 3'b100, 3'b000};
        v[12] = '{24'h1A0500, 32'h00000004, 3'b000, 3'b000, 3'b000, 3'b000};
        v[13] = '{24'h1A0500, 32'h00000000, 3'b000, 3'b000, 3'b000, 3'b000};
        v[14] = '{24'h1A1A04, 32'h1A000000, 3'b110, 3'b110, 3'b000, 3'b110};
        v[15] = '{24'h1A1A04, 32'h00000000, 3'b000, 3'b000, 3'b110, 3'b000};
        v[16] = '{24'h1A0704, 32'h00000000, 3'b000, 3'b000, 3'b000, 3'b000};

        cyc(0);
        cyc(0);
        chk("reset held", bus.held, 3'b000);
        chk("reset press", bus.press_pulse, 3'b000);
        chk("reset release", bus.release_pulse, 3'b000);
        chk("reset fire", bus.fire, 3'b000);
        rst_n = 1'b1;
        cyc(0);

        for (int i = 0; i < 17; i++) begin
            bus.key_map = v[i].km;
            bus.keycodes = v[i].kc;
            cyc(0);
            chk($sformatf("vec%0d held", i), bus.held, v[i].h);
            chk($sformatf("vec%0d press", i), bus.press_pulse, v[i].p);
            chk($sformatf("vec%0d release", i), bus.release_pulse, v[i].r);
            chk($sformatf("vec%0d fire", i), bus.fire, v[i].f);
        end

        bus.key_map = 24'h1A0704;
        bus.keycodes = 32'h1A000000;
        cyc(0);
        chk("repeat press", bus.press_pulse, 3'b100);
        chk("repeat press fire", bus.fire, 3'b100);
        nf = 0; stray = 0; first_t = 0; second_t = 0; last_t = 0;
        for (int k = 1; k <= 50; k++) begin
            cyc(1);
            if (bus.fire[2]) begin
                nf++;
                if (first_t == 0) first_t = k;
                else if (second_t == 0) second_t = k;
                last_t = k;
            end
            for (int j = 0; j < 9; j++) begin
                cyc(0);
                if (bus.fire[2]) stray++;
            end
        end
        chk("repeat fire count", nf, 6);
        chk("repeat first tick", first_t, 20);
        chk("repeat second tick", second_t, 26);
        chk("repeat last tick", last_t, 50);
        chk("repeat off-tick fires", stray, 0);
        chk("repeat still held", bus.held, 3'b100);
        bus.keycodes = 32'h0;
        cyc(0);
        chk("repeat release", bus.release_pulse, 3'b100);
        chk("repeat release held", bus.held, 3'b000);

        bus.keycodes = 32'h00000004;
        cyc(0);
        chk("rollover press", bus.press_pulse, 3'b001);
        bus.keycodes = 32'h01010101;
        nf = 0; np = 0; nr = 0; drop = 0;
        for (int k = 1; k <= 26; k++) begin
            cyc(1);
            nf += int'(bus.fire[0]);
            np += int'(|bus.press_pulse);
            nr += int'(|bus.release_pulse);
            if (!bus.held[0]) drop++;
        end
        bus.tick = 1'b0;
        chk("rollover fires", nf, 2);
        chk("rollover press pulses", np, 0);
        chk("rollover release pulses", nr, 0);
        chk("rollover held drops", drop, 0);
        bus.keycodes = 32'h0;
        cyc(0);
        chk("rollover end release", bus.release_pulse, 3'b001);

        bus.keycodes = 32'h00000004;
        cyc(0);
        for (int k = 0; k < 22; k++) cyc(1);
        bus.tick = 1'b0;
        chk("pre-reset held", bus.held, 3'b001);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("async reset held", bus.held, 3'b000);
        chk("async reset press", bus.press_pulse, 3'b000);
        chk("async reset release", bus.release_pulse, 3'b000);
        chk("async reset fire", bus.fire, 3'b000);
        cyc(0);
        chk("in reset release", bus.release_pulse, 3'b000);
        rst_n = 1'b1;
        cyc(0);
        chk("post-reset press", bus.press_pulse, 3'b001);
        chk("post-reset fire", bus.fire, 3'b001);
        chk("post-reset held", bus.held, 3'b001);
        bus.keycodes = 32'h0;
        cyc(0);
        cyc(0);

        nf = 0;
        bus.keycodes = 32'h00000004;
        cyc(0);
        nf += $countones(bus.fire);
        chk("lr first held", bus.held, 3'b001);
        bus.keycodes = 32'h00000704;
        cyc(0);
        nf += $countones(bus.fire);
`ifdef KEYCTL_LR_PRIORITY_EN
        chk("lr both held", bus.held, 3'b010);
`else
        chk("lr both held", bus.held, 3'b011);
`endif
        chk("lr second press", bus.press_pulse, 3'b010);
        bus.keycodes = 32'h00000004;
        cyc(0);
        nf += $countones(bus.fire);
        chk("lr after release held", bus.held, 3'b001);
        chk("lr release pulse", bus.release_pulse, 3'b010);
        for (int k = 0; k < 3; k++) begin
            cyc(0);
            nf += $countones(bus.fire);
        end
        chk("lr total fires", nf, 2);
        bus.keycodes = 32'h0;
        cyc(0);
        chk("lr final release", bus.release_pulse, 3'b001);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/key_action_ctrl.md
Name: key_action_ctrl

Overview:
- Parametrised successor to the single-player key decoder.
- Maps up to NUM_ACTIONS runtime-programmable USB HID keycodes against NUM_SLOTS report slots, each slot being one byte of the keyboard report.
- Produces registered per-action held levels, press and release pulses, and auto-repeat fire pulses timed in game ticks.
- Sits between the USB keycode register and the character/game FSMs.

Parameters:
- NUM_SLOTS, 4, number of 8-bit keycode slots in the report
- NUM_ACTIONS, 3, number of mapped actions (0=left, 1=right, 2=attack by convention)
- REPEAT_DELAY, 20, ticks from press to first repeat fire; 0 disables auto-repeat
- REPEAT_PERIOD, 6, ticks between repeat fires; must be >=1

Ports:
- Clk  in  1  system clock
- Reset_n  in  1  asynchronous active-low reset
- tick  in  1  one-Clk game-tick strobe (e.g. frame start); timing counters advance only on it
- keycodes  in  NUM_SLOTS*8  report slots; slot i = bits [8i+7:8i]
- key_map  in  NUM_ACTIONS*8  keycode of action a = bits [8a+7:8a]; 8'h00 = unmapped
- held  out  NUM_ACTIONS  registered key-down level per action
- press_pulse  out  NUM_ACTIONS  1-Clk pulse on press
- release_pulse  out  NUM_ACTIONS  1-Clk pulse on release
- fire  out  NUM_ACTIONS  1-Clk pulse on press and on each auto-repeat

Behaviour:
- Reset (async assert, sync release): held=0, all pulse outputs=0, every action in IDLE with counter=0.
- Matching: match[a] = key_map[a] != 0 AND any slot == key_map[a]. Slot value 8'h00 never matches.
- Rollover: if any slot == 8'h01 (ErrorRollOver):
  - match is ignored that cycle, so held, press and release do not change;
  - repeat timing for actions already held continues.
- Latency: one Clk. A keycode change sampled at edge N appears on held/press_pulse/release_pulse/fire after edge N.
- Pulses are registered and last exactly one Clk. There are no back-to-back press pulses without an intervening release.
- Per-action FSM (states IDLE, FIRST, REPEAT; counter width $clog2(max(REPEAT_DELAY,REPEAT_PERIOD)+1)):
  - IDLE, match=1: held<=1, press_pulse<=1, fire<=1, cnt<=0, go to FIRST.
  - FIRST, on tick:
    - if REPEAT_DELAY==0, stay in FIRST with no counting;
    - else if cnt==REPEAT_DELAY-1: fire<=1, cnt<=0, go to REPEAT;
    - else cnt++.
  - REPEAT, on tick: if cnt==REPEAT_PERIOD-1, fire<=1 and cnt<=0; else cnt++.
  - FIRST or REPEAT, match=0 (non-rollover cycle): held<=0, release_pulse<=1, cnt<=0, go to IDLE. Release takes priority over a coincident tick fire.
- Actions are independent. Two actions mapped to the same keycode both respond.
- Changing key_map while held behaves as a release of the old key and, if the new code is present, a press on the following cycle.
- Reset mid-hold returns the action to IDLE immediately, with no release pulse.

Optional Feature:
- Macro: KEYCTL_LR_PRIORITY_EN. Requires NUM_ACTIONS>=2.
- Defined: actions 0 and 1 are a mutually exclusive left/right pair with last-pressed-wins.
  - A one-bit register records whichever of the two pressed most recently.
  - While both are held, the non-winning action's held and fire are forced to 0; its press and release pulses are unaffected.
  - If both rise on the same edge, action 1 wins.
  - When the winner is released, the other action's held re-asserts on the next Clk with no new fire.
- Undefined: actions 0 and 1 are fully independent, and both may be held simultaneously.

Test Plan:
- Reset, then key_map={1A,07,04}, keycodes=00000004 -> one cycle later held=001, press_pulse=001 and fire=001 for one Clk; clear keycodes -> release_pulse=001 one Clk.
- Hold 8'h1A in slot 3 with REPEAT_DELAY=20, REPEAT_PERIOD=6, a tick every 10 Clk -> fire[2] on press, at the 20th tick, then every 6th tick; 50 ticks total gives 6 fires.
- keycodes=01010101 while action 0 is held and cleared otherwise -> held unchanged and no press/release pulses; repeat fires continue on tick.
- Reset_n asserted mid-REPEAT -> all outputs 0 asynchronously; after release with the key still present -> a fresh press_pulse and fire.
- key_map[0]=00 with keycodes=00000000 -> held[0] never asserts, and no pulses on any action.
- With KEYCTL_LR_PRIORITY_EN: press 04, then 07, then release 07 -> held goes 01 -> 10 -> 01, with exactly 2 fires total in that window (REPEAT_DELAY large).
